// File: rtl/rr_mux_pkg.sv
// ---------------------------------------------------------------------------
// rr_mux_pkg
//   Shared definitions for the 4-lane round-robin mux and its 1:4 demux
//   counterpart: the 2-bit lane index type, the lane constants and a small
//   modulo-4 lane arithmetic helper.
// ---------------------------------------------------------------------------
package rr_mux_pkg;

    localparam int unsigned NLANES = 4;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE1 = 2'd0;
    localparam lane_t LANE2 = 2'd1;
    localparam lane_t LANE3 = 2'd2;
    localparam lane_t LANE4 = 2'd3;

    // Lane index offset by k, wrapping modulo 4.
    function automatic lane_t lane_add(input lane_t a, input int unsigned k);
        return a + lane_t'(k);
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
//   Combinational rotating-priority arbiter for four requesters. The search
//   starts at the lane after `last` and wraps; the first requesting lane wins.
// Ports
//   req       in   4  request per lane (bit 0 = lane 1)
//   last      in   2  most recently granted lane
//   gnt_valid out  1  a lane is granted
//   gnt       out  2  granted lane index (equals `last` when nothing granted)
// ---------------------------------------------------------------------------
module rr_arb4
    import rr_mux_pkg::*;
(
    input  logic [NLANES-1:0] req,
    input  lane_t             last,
    output logic              gnt_valid,
    output lane_t             gnt
);

    // Offset NLANES wraps back onto `last` itself, so it is searched last.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = last;
        for (int unsigned k = 1; k <= NLANES; k++) begin
            if (!gnt_valid && req[lane_add(last, k)]) begin
                gnt_valid = 1'b1;
                gnt       = lane_add(last, k);
            end
        end
    end

endmodule

// File: rtl/rr_mux4.sv
// ---------------------------------------------------------------------------
// rr_mux4
//   4:1 round-robin multiplexer with valid/ready handshakes. Merges four
//   source lanes onto one registered output word and tags each word with the
//   lane it came from, so a downstream 1:4 demux can route it back.
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      synchronous active-high reset
//   i1..i4   in   WIDTH  lane data
//   v1..v4   in   1      lane valid
//   r1..r4   out  1      lane ready (combinational)
//   y        out  WIDTH  output word (registered)
//   sel      out  2      lane index of y (registered)
//   y_valid  out  1      output word valid (registered)
//   y_ready  in   1      downstream ready
// ---------------------------------------------------------------------------
module rr_mux4
    import rr_mux_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic [WIDTH-1:0] i4,
    input  logic             v1,
    input  logic             v2,
    input  logic             v3,
    input  logic             v4,
    output logic             r1,
    output logic             r2,
    output logic             r3,
    output logic             r4,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       sel,
    output logic             y_valid,
    input  logic             y_ready
);

    logic [WIDTH-1:0]  r_y;
    lane_t             r_sel;
    logic              r_y_valid;
    lane_t             r_last;

    logic              w_load_en;
    logic              w_gnt_valid;
    lane_t             w_gnt;
    logic [WIDTH-1:0]  w_gnt_data;
    logic [NLANES-1:0] w_ready;

    // Output register is free when empty or being drained this cycle.
    assign w_load_en = !r_y_valid || y_ready;

    rr_arb4 u_arb (
        .req       ({v4, v3, v2, v1}),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt       (w_gnt)
    );

    always_comb begin
        w_gnt_data = i1;
        case (w_gnt)
            LANE2:   w_gnt_data = i2;
            LANE3:   w_gnt_data = i3;
            LANE4:   w_gnt_data = i4;
            default: w_gnt_data = i1;
        endcase
    end

    always_comb begin
        w_ready = '0;
        if (w_load_en && w_gnt_valid && !rst) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    assign r1 = w_ready[0];
    assign r2 = w_ready[1];
    assign r3 = w_ready[2];
    assign r4 = w_ready[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_sel     <= LANE1;
            r_y_valid <= 1'b0;
            r_last    <= LANE4;
        end else if (w_load_en) begin
            if (w_gnt_valid) begin
                r_y       <= w_gnt_data;
                r_sel     <= w_gnt;
                r_y_valid <= 1'b1;
                r_last    <= w_gnt;
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign y       = r_y;
    assign sel     = r_sel;
    assign y_valid = r_y_valid;

endmodule

// File: tb/tb_rr_mux4.sv
module tb_rr_mux4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din [4];
    logic [3:0] vin;
    logic       r1, r2, r3, r4;
    logic [7:0] y;
    logic [1:0] sel;
    logic       y_valid;
    logic       y_ready;

    int n_total = 0;
    int n_bad   = 0;

    // Reference state: contents of the output stage and the round-robin pointer.
    int         m_last = 3;
    logic       m_yv   = 1'b0;
    logic [7:0] m_y    = '0;
    int         m_sel  = 0;
    logic [3:0] m_acc  = '0;
    logic [7:0] q [4][$];

    always #5 clk = ~clk;

    rr_mux4 #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .i1      (din[0]),
        .i2      (din[1]),
        .i3      (din[2]),
        .i4      (din[3]),
        .v1      (vin[0]),
        .v2      (vin[1]),
        .v3      (vin[2]),
        .v4      (vin[3]),
        .r1      (r1),
        .r2      (r2),
        .r3      (r3),
        .r4      (r4),
        .y       (y),
        .sel     (sel),
        .y_valid (y_valid),
        .y_ready (y_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs against the reference just before the
    // edge, then advance the reference across the edge. Inputs must already be set.
    task automatic cycle(input bit chk);
        int         g;
        bit         gv;
        bit         load;
        logic [3:0] exp_r;
        int         s;
        #4;
        gv = 0;
        g  = 0;
        for (int k = 1; k <= 4; k++) begin
            if (!gv && vin[(m_last + k) % 4]) begin
                gv = 1;
                g  = (m_last + k) % 4;
            end
        end
        load  = !m_yv || y_ready;
        exp_r = (!rst && load && gv) ? 4'(1 << g) : 4'b0000;
        if (chk) begin
            check("ready", {28'd0, r4, r3, r2, r1}, {28'd0, exp_r});
            check("y_valid", {31'd0, y_valid}, {31'd0, m_yv});
            check("y", {24'd0, y}, {24'd0, m_y});
            check("sel", {30'd0, sel}, 32'(m_sel));
            if (y_valid && y_ready && !rst) begin
                s = int'(sel);
                check("sb_nonempty", {31'd0, q[s].size() != 0}, 32'd1);
                if (q[s].size() != 0) check("sb_data", {24'd0, y}, {24'd0, q[s].pop_front()});
            end
        end
        m_acc = exp_r & vin;
        for (int k = 0; k < 4; k++) if (m_acc[k]) q[k].push_back(din[k]);
        @(posedge clk);
        if (rst) begin
            m_yv = 0; m_y = '0; m_sel = 0; m_last = 3; m_acc = '0;
            for (int k = 0; k < 4; k++) q[k].delete();
        end else if (load) begin
            if (gv) begin
                m_yv = 1; m_y = din[g]; m_sel = g; m_last = g;
            end else begin
                m_yv = 0;
            end
        end
        #1;
    endtask

    logic [7:0] held_y;
    logic [1:0] held_sel;
    logic [1:0] exp_seq [5];

    initial begin
        // 1. reset with all lanes valid
        rst = 1'b1; y_ready = 1'b1; vin = 4'hF;
        din[0] = 8'h01; din[1] = 8'h02; din[2] = 8'h03; din[3] = 8'h04;
        cycle(0);
        cycle(1);
        check("rst_yv", {31'd0, y_valid}, 32'd0);
        check("rst_y", {24'd0, y}, 32'd0);

        // 2. single lane
        rst = 1'b0; vin = 4'b0100; din[2] = 8'hA5;
        cycle(1);
        vin = 4'b0000;
        check("t2_y", {24'd0, y}, 32'hA5);
        check("t2_sel", {30'd0, sel}, 32'd2);
        check("t2_yv", {31'd0, y_valid}, 32'd1);
        cycle(1);

        // 3. all lanes valid, rotation from a fresh reset
        rst = 1'b1; cycle(1); rst = 1'b0;
        din[0] = 8'h11; din[1] = 8'h22; din[2] = 8'h33; din[3] = 8'h44;
        vin = 4'hF; y_ready = 1'b1;
        exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd3; exp_seq[4] = 2'd0;
        for (int n = 0; n < 5; n++) begin
            cycle(1);
            check("t3_sel", {30'd0, sel}, {30'd0, exp_seq[n]});
            check("t3_y", {24'd0, y}, 32'({exp_seq[n], 2'b00} + 8'h11 * (exp_seq[n] + 1) - {exp_seq[n], 2'b00}));
        end

        // 4. backpressure for 5 cycles
        y_ready = 1'b0;
        held_y = y; held_sel = sel;
        for (int n = 0; n < 5; n++) begin
            cycle(1);
            check("t4_y_hold", {24'd0, y}, {24'd0, held_y});
            check("t4_sel_hold", {30'd0, sel}, {30'd0, held_sel});
        end
        y_ready = 1'b1;
        cycle(1);
        check("t4_next", {30'd0, sel}, 32'(held_sel + 2'd1));

        // 5. bubble, then lane 2 arrives
        vin = 4'b0000;
        cycle(1);
        cycle(1);
        check("t5_bubble", {31'd0, y_valid}, 32'd0);
        vin = 4'b0010; din[1] = 8'h5C;
        cycle(1);
        vin = 4'b0000;
        check("t5_sel", {30'd0, sel}, 32'd1);
        check("t5_y", {24'd0, y}, 32'h5C);

        // 6. reset while a word is stalled on the output
        vin = 4'hF; y_ready = 1'b0;
        cycle(1);
        rst = 1'b1;
        cycle(1);
        check("t6_flush", {31'd0, y_valid}, 32'd0);
        rst = 1'b0; y_ready = 1'b1;
        cycle(1);
        check("t6_first", {30'd0, sel}, 32'd0);

        // Random traffic: sources hold their word until it is accepted.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            y_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) begin
                if (!(vin[k] && !m_acc[k])) begin
                    vin[k] = ($urandom_range(0, 2) != 0);
                    din[k] = 8'($urandom);
                end
            end
            cycle(1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
